sprite_animator: RTL and testbench
==================================

SPRITE_ANIMATOR -- requirements
Module: sprite_animator

Interface
REQ-001 SHALL have parameter SPR_W, default 80, meaning sprite cell width in pixels.
REQ-002 SHALL have parameter SPR_H, default 108, meaning sprite cell height in pixels.
REQ-003 SHALL have parameter NUM_STATES, default 6, meaning animation count.
REQ-004 SHALL have parameter FRAMES, default 8, meaning frames per animation.
REQ-005 SHALL have parameter HOLD_TICKS, default 4, meaning frame_clk ticks per frame, at least 1.
REQ-006 SHALL have parameter ADDR_W, default 19, meaning ROM address width.
REQ-007 SHALL have parameter TRANSPARENT, default 8'h00, meaning key colour.
REQ-008 SHALL have port Clk, input, 1 bit: the single clock.
REQ-009 SHALL have port Reset_n, input, 1 bit: asynchronous active-low reset.
REQ-010 SHALL have port frame_clk, input, 1 bit: ~60 Hz frame strobe, level signal.
REQ-011 SHALL have port anim_state, input, 8 bits: requested animation index.
REQ-012 SHALL have port anim_oneshot, input, 1 bit: 1 = play once and hold the last frame.
REQ-013 SHALL have port facing, input, 1 bit: 1 = horizontal mirror.
REQ-014 SHALL have ports pos_x and pos_y, input, 10 bits each: sprite top-left corner.
REQ-015 SHALL have ports DrawX and DrawY, input, 10 bits each: current pixel coordinates.
REQ-016 SHALL have port rom_addr, output, ADDR_W bits: sprite ROM read address.
REQ-017 SHALL have port rom_data, input, 8 bits: ROM data, returned one Clk after rom_addr.
REQ-018 SHALL have port is_character, output, 1 bit: opaque sprite pixel.
REQ-019 SHALL have port data_Out, output, 8 bits: palette index.
REQ-020 SHALL have port frame_num, output, 8 bits: current frame.
REQ-021 SHALL have port anim_done, output, 1 bit: one-shot complete.

Function
REQ-022 SHALL detect a frame_clk rising edge, "tick", as a registered-sample 0 to 1 transition in the Clk domain.
REQ-023 SHALL latch pos_x and pos_y only on a tick, so there is no mid-frame tearing.
REQ-024 SHALL, on each tick, increment hold; when hold equals HOLD_TICKS-1, hold becomes 0 and the frame advances.
REQ-025 SHALL, in loop mode (anim_oneshot=0), wrap the frame from FRAMES-1 to 0.
REQ-026 SHALL, in one-shot mode, stop the frame at FRAMES-1 and set anim_done, which stays set until the state changes.
REQ-027 SHALL, on any Clk where anim_state differs from the registered current state, load the new state and clear frame, hold and anim_done; this takes priority over a simultaneous tick.
REQ-028 SHALL treat anim_state of NUM_STATES or greater as state 0.
REQ-029 SHALL assert in_box when DrawX−px is in [0,SPR_W) and DrawY−py is in [0,SPR_H), where px and py are the latched position, using unsigned 11-bit compares with no wrap-around.
REQ-030 SHALL drive rom_addr registered as ((state*FRAMES+frame)*SPR_W*SPR_H + dy*SPR_W + dx), truncated to ADDR_W; rom_addr SHALL be 0 when not in_box.
REQ-031 SHALL delay in_box by one Clk to align with rom_data; is_character = in_box_d AND rom_data≠TRANSPARENT.
REQ-032 SHALL make data_Out equal rom_data when is_character is 1, and 0 otherwise.
REQ-033 SHALL have a total pixel latency of DrawX/DrawY to is_character/data_Out of 2 Clk.
REQ-034 SHALL drive frame_num as the zero-extended frame register.

Reset
REQ-035 SHALL, while Reset_n=0, asynchronously clear state, frame, hold, anim_done, latched position, frame_clk sample, pipeline registers, rom_addr, is_character and data_Out.
REQ-036 SHALL, on Reset_n deassertion mid-animation, restart from state 0, frame 0, with no spurious tick if frame_clk is already high.

Configuration
REQ-037 SHALL use macro SPRITE_MIRROR_EN: when defined, facing=1 replaces dx with SPR_W−1−dx in rom_addr.
REQ-038 SHALL, when SPRITE_MIRROR_EN is undefined, ignore facing, while the port is still present.

Verification
REQ-039 SHALL cover: hold anim_state=2, loop mode, 8×HOLD_TICKS ticks -> frame_num runs 0..7 then returns to 0, each value held for 4 ticks.
REQ-040 SHALL cover: anim_oneshot=1, 40 ticks -> frame_num stops at 7, anim_done=1; then change anim_state to 1 -> frame_num=0 and anim_done=0 on the next Clk.
REQ-041 SHALL cover: pos latched at (400,200), DrawX=400, DrawY=201, frame 0, state 0 -> rom_addr=80; DrawX=480 -> not in_box and rom_addr=0.
REQ-042 SHALL cover: rom_data=8'h00 inside the box -> is_character=0 and data_Out=0; rom_data=8'h3C -> is_character=1 and data_Out=8'h3C, 2 Clk after DrawX.
REQ-043 SHALL cover, with SPRITE_MIRROR_EN: facing=1, DrawX=400 -> dx 79 used; without the macro -> dx 0 used.
REQ-044 SHALL cover: anim_state change coincident with a tick -> frame=0 and hold=0; Reset_n pulse low mid-frame -> all outputs are 0 immediately.

Source files
------------

// File: rtl/sprite_animator.sv
// rtl/sprite_animator.sv - frame-stepped sprite animation with a 2-Clk ROM pixel pipeline
// Optional SPRITE_MIRROR_EN: facing=1 mirrors the sprite horizontally in the ROM address.
module sprite_animator #(
    parameter int         SPR_W       = 80,
    parameter int         SPR_H       = 108,
    parameter int         NUM_STATES  = 6,
    parameter int         FRAMES      = 8,
    parameter int         HOLD_TICKS  = 4,
    parameter int         ADDR_W      = 19,
    parameter logic [7:0] TRANSPARENT = 8'h00
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              frame_clk,
    input  logic [7:0]        anim_state,
    input  logic              anim_oneshot,
    input  logic              facing,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic              is_character,
    output logic [7:0]        data_Out,
    output logic [7:0]        frame_num,
    output logic              anim_done
);

    localparam int SW = (NUM_STATES > 1) ? $clog2(NUM_STATES) : 1;
    localparam int FW = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_TICKS - 1);
    localparam logic [31:0]   W_U        = 32'(SPR_W);
    localparam logic [31:0]   H_U        = 32'(SPR_H);
    localparam logic [31:0]   F_U        = 32'(FRAMES);
    localparam logic [31:0]   NS_U       = 32'(NUM_STATES);
    localparam logic [31:0]   CELL_U     = 32'(SPR_W * SPR_H);

    // Animation control registers
    logic          fclk_q,   fclk_d;
    logic          primed_q, primed_d;
    logic [SW-1:0] state_q,  state_d;
    logic [FW-1:0] frame_q,  frame_d;
    logic [HW-1:0] hold_q,   hold_d;
    logic          done_q,   done_d;
    logic [9:0]    px_q,     px_d;
    logic [9:0]    py_q,     py_d;

    // Pixel pipeline registers
    logic [ADDR_W-1:0] rom_addr_q,   rom_addr_d;
    logic              in_box_q,     in_box_d;
    logic              in_box_dly_q, in_box_dly_d;

    logic          tick;
    logic [SW-1:0] req_state;
    logic [FW-1:0] frame_inc;
    logic [10:0]   dx_w;
    logic [10:0]   dy_w;
    logic [10:0]   dx_eff;

    always_comb begin
        fclk_d    = frame_clk;
        primed_d  = 1'b1;
        state_d   = state_q;
        frame_d   = frame_q;
        hold_d    = hold_q;
        done_d    = done_q;
        px_d      = px_q;
        py_d      = py_q;
        frame_inc = frame_q + 1'b1;

        // primed_q masks the first sample after reset so a high frame_clk is not a tick
        tick = frame_clk & ~fclk_q & primed_q;

        if (32'(anim_state) >= NS_U) begin
            req_state = '0;
        end else begin
            req_state = SW'(anim_state);
        end

        if (tick) begin
            px_d = pos_x;
            py_d = pos_y;
        end

        if (req_state != state_q) begin
            state_d = req_state;
            frame_d = '0;
            hold_d  = '0;
            done_d  = 1'b0;
        end else if (tick) begin
            if (hold_q == HOLD_LAST) begin
                hold_d = '0;
                if (frame_q == FRAME_LAST) begin
                    if (anim_oneshot) begin
                        done_d = 1'b1;
                    end else begin
                        frame_d = '0;
                    end
                end else begin
                    frame_d = frame_inc;
                    if (anim_oneshot && (frame_inc == FRAME_LAST)) begin
                        done_d = 1'b1;
                    end
                end
            end else begin
                hold_d = hold_q + 1'b1;
            end
        end
    end

    // A pixel left of / above the sprite wraps to >= 1024, which is always outside the box
    always_comb begin
        dx_w = {1'b0, DrawX} - {1'b0, px_q};
        dy_w = {1'b0, DrawY} - {1'b0, py_q};
`ifdef SPRITE_MIRROR_EN
        dx_eff = facing ? (11'(SPR_W - 1) - dx_w) : dx_w;
`else
        dx_eff = dx_w;
`endif
        in_box_d = (32'(dx_w) < W_U) && (32'(dy_w) < H_U);
        if (in_box_d) begin
            rom_addr_d = ADDR_W'((32'(state_q) * F_U + 32'(frame_q)) * CELL_U
                                 + 32'(dy_w) * W_U + 32'(dx_eff));
        end else begin
            rom_addr_d = '0;
        end
        in_box_dly_d = in_box_q;
    end

`ifndef SPRITE_MIRROR_EN
    logic unused_facing;
    assign unused_facing = facing;
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fclk_q       <= 1'b0;
            primed_q     <= 1'b0;
            state_q      <= '0;
            frame_q      <= '0;
            hold_q       <= '0;
            done_q       <= 1'b0;
            px_q         <= '0;
            py_q         <= '0;
            rom_addr_q   <= '0;
            in_box_q     <= 1'b0;
            in_box_dly_q <= 1'b0;
        end else begin
            fclk_q       <= fclk_d;
            primed_q     <= primed_d;
            state_q      <= state_d;
            frame_q      <= frame_d;
            hold_q       <= hold_d;
            done_q       <= done_d;
            px_q         <= px_d;
            py_q         <= py_d;
            rom_addr_q   <= rom_addr_d;
            in_box_q     <= in_box_d;
            in_box_dly_q <= in_box_dly_d;
        end
    end

    // rom_data is already one Clk behind rom_addr, so the pixel outputs stay combinational
    assign rom_addr     = rom_addr_q;
    assign is_character = in_box_dly_q && (rom_data != TRANSPARENT);
    assign data_Out     = is_character ? rom_data : 8'h00;
    assign frame_num    = 8'(frame_q);
    assign anim_done    = done_q;

endmodule

// File: tb/tb_sprite_animator.sv
// tb/tb_sprite_animator.sv - randomized self-checking bench for sprite_animator
module tb_sprite_animator;

    localparam int SPR_W      = 80;
    localparam int SPR_H      = 108;
    localparam int NUM_STATES = 6;
    localparam int FRAMES     = 8;
    localparam int HOLD       = 4;
    localparam int ADDR_W     = 19;

    logic              Clk;
    logic              Reset_n;
    logic              frame_clk;
    logic [7:0]        anim_state;
    logic              anim_oneshot;
    logic              facing;
    logic [9:0]        pos_x, pos_y, DrawX, DrawY;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_data;
    logic              is_character;
    logic [7:0]        data_Out;
    logic [7:0]        frame_num;
    logic              anim_done;

    sprite_animator #(
        .SPR_W(SPR_W), .SPR_H(SPR_H), .NUM_STATES(NUM_STATES), .FRAMES(FRAMES),
        .HOLD_TICKS(HOLD), .ADDR_W(ADDR_W), .TRANSPARENT(8'h00)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .anim_state(anim_state),
        .anim_oneshot(anim_oneshot), .facing(facing), .pos_x(pos_x), .pos_y(pos_y),
        .DrawX(DrawX), .DrawY(DrawY), .rom_addr(rom_addr), .rom_data(rom_data),
        .is_character(is_character), .data_Out(data_Out), .frame_num(frame_num),
        .anim_done(anim_done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: frame position is derived from ticks counted since the last state load
    int m_state, m_os, m_ticks, m_px, m_py;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    function automatic int map_state(input int s);
        return (s >= NUM_STATES) ? 0 : s;
    endfunction

    function automatic int exp_frame();
        int adv;
        adv = m_ticks / HOLD;
        if (m_os != 0) return (adv >= FRAMES - 1) ? FRAMES - 1 : adv;
        return adv % FRAMES;
    endfunction

    function automatic int exp_done();
        return ((m_os != 0) && (m_ticks / HOLD >= FRAMES - 1)) ? 1 : 0;
    endfunction

    task automatic check_anim(input string tag);
        check_eq({tag, ".frame"}, 32'(frame_num), 32'(exp_frame()));
        check_eq({tag, ".done"}, 32'(anim_done), 32'(exp_done()));
    endtask

    task automatic model_reset();
        m_state = 0; m_os = 0; m_ticks = 0; m_px = 0; m_py = 0;
    endtask

    // Drives a request; with_tick asserts frame_clk on the same Clk edge
    task automatic drive_state(input int s, input bit os, input bit with_tick, input string tag);
        bit change;
        change = (map_state(s) != m_state);
        anim_state = 8'(s);
        if (change) anim_oneshot = os;
        if (with_tick) frame_clk = 1'b1;
        step();
        if (change) begin
            m_state = map_state(s); m_os = int'(os); m_ticks = 0;
        end else if (with_tick) begin
            m_ticks++;
        end
        if (with_tick) begin
            m_px = int'(pos_x); m_py = int'(pos_y);
        end
        check_anim(tag);
        if (with_tick) begin
            frame_clk = 1'b0;
            step();
        end
    endtask

    task automatic tick(input string tag);
        drive_state(int'(anim_state), anim_oneshot, 1'b1, tag);
    endtask

    task automatic pix_check(input int xoff, input int yoff, input logic [7:0] rdata, input string tag);
        int dxv, dyv, ex, ey, exx, inb;
        longint a;
        dxv = (m_px + xoff) & 1023;
        dyv = (m_py + yoff) & 1023;
        DrawX = 10'(dxv);
        DrawY = 10'(dyv);
        ex = dxv - m_px;
        ey = dyv - m_py;
        inb = (ex >= 0 && ex < SPR_W && ey >= 0 && ey < SPR_H) ? 1 : 0;
        exx = ex;
`ifdef SPRITE_MIRROR_EN
        if (facing) exx = SPR_W - 1 - ex;
`endif
        a = longint'((m_state * FRAMES + exp_frame()) * SPR_W * SPR_H + ey * SPR_W + exx);
        a = (inb != 0) ? (a % (longint'(1) << ADDR_W)) : 0;
        step();
        check_eq({tag, ".rom_addr"}, 32'(rom_addr), 32'(a));
        rom_data = rdata;
        step();
        check_eq({tag, ".is_char"}, 32'(is_character), 32'((inb != 0) && (rdata != 8'h00)));
        check_eq({tag, ".data_out"}, 32'(data_Out),
                 32'(((inb != 0) && (rdata != 8'h00)) ? rdata : 8'h00));
    endtask

    initial begin
        Reset_n = 1'b0; frame_clk = 1'b0; anim_state = 8'd0; anim_oneshot = 1'b0;
        facing = 1'b0; pos_x = 10'd100; pos_y = 10'd50; DrawX = 10'd0; DrawY = 10'd0;
        rom_data = 8'h3C;
        model_reset();
        step(); step();
        check_eq("rst.rom_addr", 32'(rom_addr), 32'd0);
        check_eq("rst.is_char", 32'(is_character), 32'd0);
        check_eq("rst.data_out", 32'(data_Out), 32'd0);
        check_anim("rst");

        // Release with frame_clk already high: no tick, so the position stays unlatched
        frame_clk = 1'b1;
        Reset_n = 1'b1;
        step(); step(); step();
        check_anim("rel_high");
        pix_check(5, 0, 8'h3C, "no_spurious");
        frame_clk = 1'b0;
        step();

        // Loop mode run through every frame and back to 0
        drive_state(2, 1'b0, 1'b0, "load2");
        for (int i = 0; i < FRAMES * HOLD; i++) tick("loop");
        check_eq("loop.wrap", 32'(frame_num), 32'd0);

        // One-shot run stops on the last frame
        drive_state(4, 1'b1, 1'b0, "load4os");
        for (int i = 0; i < 40; i++) tick("oneshot");
        check_eq("oneshot.last", 32'(frame_num), 32'(FRAMES - 1));
        check_eq("oneshot.done", 32'(anim_done), 32'd1);
        drive_state(1, 1'b0, 1'b0, "after_os");

        // Box and address boundaries
        drive_state(0, 1'b0, 1'b0, "load0");
        pos_x = 10'd400; pos_y = 10'd200;
        tick("latch");
        pix_check(0, 1, 8'h00, "box_transp");
        check_eq("box.addr80_frame", 32'(frame_num), 32'd0);
        pix_check(SPR_W, 1, 8'h3C, "box_right_edge");
        pix_check(0, 1, 8'h3C, "box_opaque");
        pix_check(-1, 0, 8'h3C, "box_left_edge");
        pix_check(0, SPR_H, 8'h3C, "box_bottom_edge");
        facing = 1'b1;
        pix_check(0, 0, 8'h11, "mirror");
        facing = 1'b0;

        // State change coincident with a tick restarts frame and hold
        for (int i = 0; i < 6; i++) tick("pre_coinc");
        drive_state(3, 1'b0, 1'b1, "coinc");
        for (int i = 0; i < HOLD; i++) tick("post_coinc");

        // Mid-frame reset clears outputs without waiting for a clock
        DrawX = 10'd403; DrawY = 10'd201; rom_data = 8'h3C;
        step(); step();
        check_eq("pre_rst.is_char", 32'(is_character), 32'd1);
        Reset_n = 1'b0;
        #1;
        check_eq("async_rst.rom_addr", 32'(rom_addr), 32'd0);
        check_eq("async_rst.is_char", 32'(is_character), 32'd0);
        check_eq("async_rst.data_out", 32'(data_Out), 32'd0);
        check_eq("async_rst.frame", 32'(frame_num), 32'd0);
        check_eq("async_rst.done", 32'(anim_done), 32'd0);
        step();
        Reset_n = 1'b1;
        model_reset();
        step();
        m_state = map_state(int'(anim_state));
        m_os = int'(anim_oneshot);
        check_anim("post_rst");

        for (int it = 0; it < 400; it++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r <= 4) begin
                pos_x = 10'($urandom_range(0, 1023));
                pos_y = 10'($urandom_range(0, 1023));
                tick("rnd_tick");
            end else if (r <= 6) begin
                drive_state(int'($urandom_range(0, 9)), 1'($urandom), 1'b0, "rnd_state");
            end else if (r == 7) begin
                drive_state(int'($urandom_range(0, 9)), 1'($urandom), 1'b1, "rnd_coinc");
            end else begin
                logic [7:0] rd;
                rd = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
                facing = 1'($urandom);
                pix_check(int'($urandom_range(0, SPR_W + 16)) - 8,
                          int'($urandom_range(0, SPR_H + 16)) - 8, rd, "rnd_pix");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
